// File: rtl/elevator_pkg.sv
// Shared types for the elevator controllers and the group dispatcher.
package elevator_pkg;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } Direction;

  typedef enum logic [1:0] {
    DOORS_HOLD,
    DOORS_OPEN,
    DOORS_CLOSE
  } DoorsOp;

  typedef enum logic [1:0] {
    ENGINE_STOP,
    ENGINE_UP,
    ENGINE_DOWN
  } EngineOp;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    OFFER
  } DispState;

  // Unsigned floor-index distance, no wrap-around.
  function automatic int unsigned floor_dist(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/elevator_dispatcher_onehot_index.sv
// One-hot to binary index converter; o_valid flags exactly one bit set.
module onehot_index #(
  parameter int N = 5
) (
  input  logic [N-1:0]                      i_vec,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_idx,
  output logic                              o_valid
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  int unsigned w_count;

  always_comb begin
    o_idx   = '0;
    w_count = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        o_idx   = o_idx | W'(i);
        w_count = w_count + 1;
      end
    end
    o_valid = (w_count == 1);
  end

endmodule

// File: rtl/elevator_dispatcher.sv
// Group dispatcher: latches hall calls, picks floors round-robin and offers
// each one to the nearest idle car over a per-car valid/ready handshake.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int FLOORS = 5,
  parameter int CARS   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLOORS-1:0]      hallCall,
  input  logic [CARS*FLOORS-1:0] carFloor,
  input  logic [CARS-1:0]        carIdle,
  input  logic [CARS-1:0]        assignReady,
  output logic [CARS-1:0]        assignValid,
  output logic [FLOORS-1:0]      assignFloor,
  output logic [FLOORS-1:0]      pendingLight
);
  localparam int IW = (FLOORS > 1) ? $clog2(FLOORS) : 1;
  localparam int CW = (CARS > 1) ? $clog2(CARS) : 1;

  DispState          r_state;
  logic [FLOORS-1:0] r_pend;
  logic [FLOORS-1:0] r_selFloor;
  logic [CW-1:0]     r_selCar;
  logic [CARS-1:0]   r_valid;
  logic [IW-1:0]     r_rrPtr;

  logic [IW-1:0]     w_carIdx [CARS];
  logic [CARS-1:0]   w_carOneHot;
  logic [IW-1:0]     w_selFloorIdx;
  logic              w_selFloorOk;

  logic              w_floorFound;
  logic [IW-1:0]     w_floorIdx;
  logic [FLOORS-1:0] w_floorOh;
  int unsigned       w_pos;

  logic              w_carFound;
  logic [CW-1:0]     w_bestCar;
  int unsigned       w_bestDist;
  int unsigned       w_dist;

  logic              w_hs;
  logic [FLOORS-1:0] w_clear;

  for (genvar c = 0; c < CARS; c++) begin : g_car
    onehot_index #(.N(FLOORS)) u_car_idx (
      .i_vec   (carFloor[c*FLOORS +: FLOORS]),
      .o_idx   (w_carIdx[c]),
      .o_valid (w_carOneHot[c])
    );
  end

  onehot_index #(.N(FLOORS)) u_sel_idx (
    .i_vec   (r_selFloor),
    .o_idx   (w_selFloorIdx),
    .o_valid (w_selFloorOk)
  );

  // Round-robin scan of pending floors starting at r_rrPtr.
  always_comb begin
    w_floorFound = 1'b0;
    w_floorIdx   = '0;
    w_floorOh    = '0;
    w_pos        = 0;
    for (int unsigned k = 0; k < FLOORS; k++) begin
      w_pos = 32'(r_rrPtr) + k;
      if (w_pos >= FLOORS) w_pos = w_pos - FLOORS;
      if (!w_floorFound && r_pend[w_pos[IW-1:0]]) begin
        w_floorFound = 1'b1;
        w_floorIdx   = w_pos[IW-1:0];
      end
    end
    if (w_floorFound) w_floorOh[w_floorIdx] = 1'b1;
  end

  // Nearest eligible car; strict compare keeps ties on the lowest index.
  always_comb begin
    w_carFound = 1'b0;
    w_bestCar  = '0;
    w_bestDist = 0;
    w_dist     = 0;
    for (int unsigned c = 0; c < CARS; c++) begin
      if (carIdle[c] && w_carOneHot[c]) begin
        w_dist = floor_dist(32'(w_carIdx[c]), 32'(w_floorIdx));
        if (!w_carFound || (w_dist < w_bestDist)) begin
          w_carFound = 1'b1;
          w_bestDist = w_dist;
          w_bestCar  = CW'(c);
        end
      end
    end
  end

  assign w_hs    = (r_state == OFFER) && assignReady[r_selCar];
  assign w_clear = w_hs ? r_selFloor : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_rrPtr    <= '0;
      r_valid    <= '0;
      r_selFloor <= '0;
      r_selCar   <= '0;
    end else begin
      // A call on the floor being handed off in the same cycle is dropped.
      r_pend <= (r_pend | hallCall) & ~w_clear;
      case (r_state)
        IDLE: begin
          if (|r_pend) r_state <= SELECT;
        end
        SELECT: begin
          if (!(|r_pend)) begin
            r_state <= IDLE;
          end else if (w_floorFound && w_carFound) begin
            r_selCar            <= w_bestCar;
            r_selFloor          <= w_floorOh;
            r_valid             <= '0;
            r_valid[w_bestCar]  <= 1'b1;
            r_state             <= OFFER;
          end
        end
        OFFER: begin
          if (w_hs) begin
            r_valid    <= '0;
            r_selFloor <= '0;
            if (w_selFloorOk)
              r_rrPtr <= (w_selFloorIdx == IW'(FLOORS - 1)) ? '0 : w_selFloorIdx + 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign assignValid  = r_valid;
  assign assignFloor  = r_selFloor;
  assign pendingLight = r_pend;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed bench for elevator_dispatcher (FLOORS=5, CARS=2).
module tb_elevator_dispatcher;
  logic       clk;
  logic       rst;
  logic [4:0] hallCall;
  logic [9:0] carFloor;
  logic [1:0] carIdle;
  logic [1:0] assignReady;
  logic [1:0] assignValid;
  logic [4:0] assignFloor;
  logic [4:0] pendingLight;

  int checks = 0;
  int errors = 0;

  elevator_dispatcher #(.FLOORS(5), .CARS(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .hallCall     (hallCall),
    .carFloor     (carFloor),
    .carIdle      (carIdle),
    .assignReady  (assignReady),
    .assignValid  (assignValid),
    .assignFloor  (assignFloor),
    .pendingLight (pendingLight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] call;
    logic [9:0] floors;
    logic [1:0] idle;
    logic [1:0] expValid;
    logic [4:0] expFloor;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    hallCall    = '0;
    assignReady = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_call(input logic [4:0] call);
    hallCall = call;
    step();
    hallCall = '0;
  endtask

  initial begin
    int got;
    vecs[0] = '{"tie_car0",    5'b00100, {5'b10000, 5'b00001}, 2'b11, 2'b01, 5'b00100};
    vecs[1] = '{"nearest_c1",  5'b10000, {5'b01000, 5'b00001}, 2'b11, 2'b10, 5'b10000};
    vecs[2] = '{"nearest_gnd", 5'b00001, {5'b00010, 5'b00100}, 2'b11, 2'b10, 5'b00001};
    vecs[3] = '{"busy_car0",   5'b01000, {5'b00001, 5'b01000}, 2'b10, 2'b10, 5'b01000};
    vecs[4] = '{"bad_onehot",  5'b00010, {5'b10000, 5'b00110}, 2'b11, 2'b10, 5'b00010};
    vecs[5] = '{"same_floor",  5'b00010, {5'b00010, 5'b00010}, 2'b11, 2'b01, 5'b00010};

    rst = 1'b1; hallCall = '0; carFloor = {5'b10000, 5'b00001}; carIdle = 2'b11; assignReady = '0;
    do_reset();
    check("reset_valid", 32'(assignValid), 32'h0);
    check("reset_floor", 32'(assignFloor), 32'h0);
    check("reset_light", 32'(pendingLight), 32'h0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      carFloor = vecs[i].floors;
      carIdle  = vecs[i].idle;
      pulse_call(vecs[i].call);
      check({vecs[i].name, "_light"}, 32'(pendingLight), 32'(vecs[i].call));
      check({vecs[i].name, "_noval"}, 32'(assignValid), 32'h0);
      step();
      check({vecs[i].name, "_sel"}, 32'(assignValid), 32'h0);
      step();
      check({vecs[i].name, "_valid"}, 32'(assignValid), 32'(vecs[i].expValid));
      check({vecs[i].name, "_floor"}, 32'(assignFloor), 32'(vecs[i].expFloor));
      assignReady = vecs[i].expValid;
      step();
      assignReady = '0;
      check({vecs[i].name, "_hs_val"}, 32'(assignValid), 32'h0);
      check({vecs[i].name, "_hs_lgt"}, 32'(pendingLight), 32'h0);
    end

    // Backpressure: offer holds even when the car stops being idle.
    do_reset();
    carFloor = {5'b10000, 5'b00001}; carIdle = 2'b11;
    pulse_call(5'b00100);
    step(); step();
    carIdle = 2'b10;
    for (int i = 0; i < 6; i++) begin
      step();
      check("bp_valid", 32'(assignValid), 32'h1);
      check("bp_floor", 32'(assignFloor), 32'b00100);
    end
    assignReady = 2'b01;
    step();
    assignReady = '0;
    check("bp_clear_light", 32'(pendingLight), 32'h0);
    check("bp_clear_valid", 32'(assignValid), 32'h0);
    carIdle = 2'b11;

    // Round robin with immediate accept.
    do_reset();
    assignReady = 2'b11;
    pulse_call(5'b00011);
    step(); step();
    check("rr_first", 32'(assignFloor), 32'b00001);
    check("rr_first_car", 32'(assignValid), 32'h1);
    step();
    check("rr_after1", 32'(pendingLight), 32'b00010);
    step(); step();
    check("rr_second", 32'(assignFloor), 32'b00010);
    check("rr_second_car", 32'(assignValid), 32'h1);
    step();
    check("rr_empty", 32'(pendingLight), 32'h0);
    pulse_call(5'b00011);
    step(); step();
    check("rr_wrap", 32'(assignFloor), 32'b00001);
    step();
    step(); step();
    check("rr_wrap2", 32'(assignFloor), 32'b00010);
    step();
    assignReady = '0;
    check("rr_done", 32'(pendingLight), 32'h0);

    // No eligible car: wait in SELECT until car 1 goes idle.
    do_reset();
    carIdle = 2'b00;
    pulse_call(5'b00100);
    for (int i = 0; i < 5; i++) begin
      step();
      check("noelig_wait", 32'(assignValid), 32'h0);
    end
    check("noelig_light", 32'(pendingLight), 32'b00100);
    carIdle = 2'b10;
    got = 0;
    for (int i = 0; i < 2 && got == 0; i++) begin
      step();
      if (assignValid != 2'b00) got = 1;
    end
    check("noelig_timeout", 32'(got), 32'h1);
    check("noelig_car1", 32'(assignValid), 32'h2);
    check("noelig_floor", 32'(assignFloor), 32'b00100);
    carIdle = 2'b11;

    // Repeat call on the handshake edge is dropped.
    do_reset();
    pulse_call(5'b00100);
    step(); step();
    check("rep_offer", 32'(assignValid), 32'h1);
    assignReady = 2'b01;
    hallCall    = 5'b00100;
    step();
    hallCall    = '0;
    assignReady = '0;
    check("rep_light", 32'(pendingLight), 32'h0);
    step(); step(); step();
    check("rep_light_late", 32'(pendingLight), 32'h0);
    check("rep_no_offer", 32'(assignValid), 32'h0);

    // Reset during OFFER loses all calls.
    pulse_call(5'b00101);
    step(); step();
    check("rst_offer", 32'(assignValid), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_valid", 32'(assignValid), 32'h0);
    check("rst_floor", 32'(assignFloor), 32'h0);
    check("rst_light", 32'(pendingLight), 32'h0);
    step(); step(); step();
    check("rst_quiet", 32'(assignValid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
